// File: rtl/div_32bits_if.sv
// Request/result bundle between the control unit (master) and the divider (slave).
interface div_32bits_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;

  modport master (output start, is_signed, dividend, divisor,
                  input  busy, done, q, r);
  modport slave  (input  start, is_signed, dividend, divisor,
                  output busy, done, q, r);
endinterface

// File: rtl/div_32bits.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock, then a sign-fix step.
// Truncates toward zero; the remainder takes the dividend's sign.
module div_32bits #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  div_32bits_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend magnitude shifts out as quotient bits shift in
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, trial;

  assign a_mag  = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign b_mag  = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dmag_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    dvd_d   = dvd_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dmag_d  = b_mag;
          quo_d   = a_mag;
          rem_d   = '0;
          negq_d  = bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          negr_d  = bus.is_signed && bus.dividend[WIDTH-1];
          dz_d    = (bus.divisor == '0);
          cnt_d   = CNT_INIT;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        // Divide-by-zero reports all-ones / raw dividend regardless of mode.
        if (dz_q) begin
          q_d = '1;
          r_d = dvd_q;
        end else begin
          q_d = negq_q ? -quo_q : quo_q;
          r_d = negr_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      dvd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      dvd_q   <= dvd_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.q    = q_q;
  assign bus.r    = r_q;
endmodule

// File: tb/tb_div_32bits.sv
// Directed bench for div_32bits: sign rules, edge operands, divide-by-zero, handshake and reset abort.
module tb_div_32bits;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  div_32bits_if #(.WIDTH(32)) bus ();
  div_32bits #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Ends at the negedge following the edge that samples start.
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = sgn; bus.dividend = a; bus.divisor = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called one negedge after the start edge; n = cycle index at which done was seen.
  task automatic wait_done(output int n, output int nbusy);
    n = 1; nbusy = 0;
    while (!bus.done && n < 60) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    int n, nb;
    launch(sgn, a, b);
    wait_done(n, nb);
    chk({tag, " lat"}, n, 34);
    chk({tag, " q"}, bus.q, eq);
    chk({tag, " r"}, bus.r, er);
    @(negedge clk);
    chk({tag, " pulse"}, {31'd0, bus.done}, 0);
  endtask

  initial begin
    int n, nb, seen;
    n_tests = 0; n_fail = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #12;
    chk("rst busy", {31'd0, bus.busy}, 0);
    chk("rst done", {31'd0, bus.done}, 0);
    chk("rst q", bus.q, 0);
    chk("rst r", bus.r, 0);
    @(negedge clk); reset = 1'b0;

    // DIVU 100/7 with busy-length check
    launch(1'b0, 32'd100, 32'd7);
    wait_done(n, nb);
    chk("divu lat", n, 34);
    chk("divu busy cycles", nb, 33);
    chk("divu busy@done", {31'd0, bus.busy}, 0);
    chk("divu q", bus.q, 32'd14);
    chk("divu r", bus.r, 32'd2);
    @(negedge clk);
    chk("divu pulse", {31'd0, bus.done}, 0);

    run("-7/2",   1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run("7/-2",   1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run("-7/-2",  1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF);
    run("umax/1", 1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0);
    run("ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run("5/9",    1'b0, 32'd5,         32'd9,         32'd0,         32'd5);
    run("-5/9",   1'b1, 32'hFFFF_FFFB, 32'd9,         32'd0,         32'hFFFF_FFFB);
    run("sdz",    1'b1, 32'hFFFF_FFF6, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF6);
    run("udz",    1'b0, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("min/3u", 1'b0, 32'h8000_0000, 32'd3,         32'h2AAA_AAAA, 32'd2);

    // start during busy with other operands is ignored
    launch(1'b0, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n, nb);
    n = n + 5;
    chk("ign lat", n, 34);
    chk("ign q", bus.q, 32'd14);
    chk("ign r", bus.r, 32'd2);

    // back-to-back: start asserted in the done cycle
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'hFFFF_FFF9; bus.divisor = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b busy", {31'd0, bus.busy}, 1);
    wait_done(n, nb);
    chk("b2b lat", n, 34);
    chk("b2b q", bus.q, 32'hFFFF_FFFD);
    chk("b2b r", bus.r, 32'hFFFF_FFFF);

    // asynchronous reset mid-operation
    launch(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", {31'd0, bus.busy}, 0);
    chk("abort done", {31'd0, bus.done}, 0);
    chk("abort q", bus.q, 0);
    chk("abort r", bus.r, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("abort no done", seen, 0);
    run("post-rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
